dm_handshake: RTL and testbench
===============================

Name: dm_handshake

Overview:
- Data-memory responder for the CPU's load/store path: a 4 KiB word-organised RAM behind a valid/ready request channel and a valid/ready response channel.
- Models a slow memory with a parameterised wait-state count.
- Lets the CPU side be moved from single-cycle to stalling/multi-cycle operation without changing the memory map or the word/byte access semantics (byte op = DMop).

Parameters:
- ADDR_W, 10, word-address bits (2^ADDR_W words; 10 gives 4 KiB).
- LATENCY, 2, wait states before the access commits (legal 0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_op  input  1  0 = word access, 1 = byte access.
- req_addr  input  32  byte address; only [ADDR_W+1:0] used.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock domain, clk; rst is asynchronous and active-high.
- Reset values: state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, busy 0, captured request registers 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On a clock edge with req_valid=1, capture addr, we, op and wdata; load counter with LATENCY; go to WAIT.
- WAIT:
  - req_ready = 0.
  - If counter == 0: perform the access on this edge and go to RESP.
  - Else decrement the counter.
- RESP:
  - rsp_valid = 1 and rsp_rdata held stable until the handshake.
  - On an edge with rsp_ready=1, go to IDLE.
- Latency: rsp_valid rises exactly LATENCY+1 cycles after the accepting edge.
- Throughput: at most one transaction per LATENCY+3 cycles; requests are never overlapped or queued.
- Request inputs are ignored after capture; changes during WAIT/RESP have no effect.
- Word load: rsp_rdata = mem[addr[ADDR_W+1:2]]; addr[1:0] ignored.
- Word store: whole word replaced with wdata.
- Byte layout: little-endian lanes; lane k = bits [8k+7:8k], k = addr[1:0].
- Byte load: selected lane zero-extended to 32 bits.
- Byte store: wdata[7:0] written into lane k; other lanes unchanged.
- Store response: rsp_rdata = 0; a store still requires the rsp handshake.
- Address bits above ADDR_W+1 are ignored, so addresses alias modulo 2^(ADDR_W+2).
- Reset during WAIT: the pending store is abandoned and RAM is unchanged.
- Reset during RESP: the response is dropped and rsp_valid goes to 0 immediately.
- req_valid asserted on the same edge that RESP→IDLE completes is not accepted until the next IDLE edge.

Optional Feature:
- Macro: DM_ALIGN_CHK_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0), valid with rsp_valid.
  - A word access with addr[1:0] != 0 performs no RAM write, returns rsp_rdata = 0 and sets rsp_err = 1.
  - Byte accesses never flag an error.
  - rsp_err clears on return to IDLE.
- Undefined: no rsp_err port; word accesses ignore addr[1:0] as described above.

Test Plan:
1. LATENCY=2. Store word 0xDEADBEEF to 0x10, then load 0x10 with rsp_ready=1 → each rsp_valid rises 3 cycles after accept; load returns 0xDEADBEEF; store returns 0x00000000.
2. Store word 0x11223344 to 0x10, byte store 0xAA to 0x13, byte load 0x12 → 0x00000022; word load 0x10 → 0xAA223344.
3. Hold rsp_ready=0 for 5 cycles in RESP while driving req_valid=1 → rsp_valid/rsp_rdata stable, req_ready=0, no second request accepted; release → IDLE next edge.
4. LATENCY=0, rsp_ready tied 1, req_valid tied 1 with loads → a new accept every 3 cycles; rsp_valid pulses 1 cycle each.
5. mem[0x20]=0x5. Start a store of 0x9 to 0x20 and assert rst during WAIT → busy=0 and rsp_valid=0 asynchronously; later load 0x20 → 0x00000005.
6. With DM_ALIGN_CHK_EN: word store 0x12345678 to 0x21 → rsp_err=1; word load 0x20 → unchanged contents, rsp_err=0.

Source files
------------

// File: rtl/dm_handshake.sv
// dm_handshake: word-organised data RAM behind valid/ready request and response channels, LATENCY wait states per access.
// Optional feature macro DM_ALIGN_CHK_EN adds rsp_err_o, which flags word accesses to non-word-aligned addresses.
module dm_handshake #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic        req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
`ifdef DM_ALIGN_CHK_EN
    output logic        rsp_err_o,
`endif
    output logic        busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                op_q, op_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
`ifdef DM_ALIGN_CHK_EN
    logic                err_q, err_d;
`endif

    logic [31:0]         mem [2**ADDR_W];
    logic [ADDR_W-1:0]   widx;
    logic [1:0]          lane;
    logic [31:0]         cur_word;
    logic [31:0]         byte_word;
    logic [31:0]         wr_word;
    logic                bad;
    logic                commit;
    logic                mem_we;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

    assign widx      = addr_q[ADDR_W+1:2];
    assign lane      = addr_q[1:0];
    assign cur_word  = mem[widx];
    assign byte_word = {24'h0, cur_word[{lane, 3'b000} +: 8]};

`ifdef DM_ALIGN_CHK_EN
    assign bad = !op_q && (lane != 2'b00);
`else
    assign bad = 1'b0;
`endif

    // Byte stores merge into the current word so the other lanes survive.
    always_comb begin
        wr_word = cur_word;
        if (op_q) begin
            wr_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            wr_word = wdata_q;
        end
    end

    assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we = commit && we_q && !bad;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
`ifdef DM_ALIGN_CHK_EN
        err_d       = err_q;
`endif
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i[ADDR_W+1:0];
                    we_d    = req_we_i;
                    op_d    = req_op_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (we_q || bad) begin
                        rdata_d = 32'h0;
                    end else if (op_q) begin
                        rdata_d = byte_word;
                    end else begin
                        rdata_d = cur_word;
                    end
`ifdef DM_ALIGN_CHK_EN
                    err_d   = bad;
`endif
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
`ifdef DM_ALIGN_CHK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            op_q    <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef DM_ALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DM_ALIGN_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    // RAM contents survive reset; an async reset in WAIT drops mem_we before the commit edge.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[widx] <= wr_word;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign rsp_rdata_o = rdata_q;
`ifdef DM_ALIGN_CHK_EN
    assign rsp_err_o   = err_q;
`endif

endmodule

// File: tb/tb_dm_handshake.sv
// Bench for dm_handshake: transaction-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_dm_handshake;

    localparam int L = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst1;
    logic        req_valid, req_we, req_op, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, busy;
    logic [31:0] rsp_rdata;
    logic        req_ready1, rsp_valid1, busy1;
    logic [31:0] rsp_rdata1;
`ifdef DM_ALIGN_CHK_EN
    logic        rsp_err, rsp_err1;
`endif

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;

    dm_handshake #(.ADDR_W(10), .LATENCY(L)) u0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
`ifdef DM_ALIGN_CHK_EN
        .rsp_err_o(rsp_err),
`endif
        .busy_o(busy)
    );

    dm_handshake #(.ADDR_W(10), .LATENCY(0)) u1 (
        .clk_i(clk), .rst_i(rst1),
        .req_valid_i(1'b1), .req_ready_o(req_ready1),
        .req_we_i(1'b0), .req_op_i(1'b0),
        .req_addr_i(32'h0), .req_wdata_i(32'h0),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(1'b1),
        .rsp_rdata_o(rsp_rdata1),
`ifdef DM_ALIGN_CHK_EN
        .rsp_err_o(rsp_err1),
`endif
        .busy_o(busy1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding request, response due LATENCY+1 edges after acceptance.
    logic [31:0] mm [1024];
    bit          m_pend = 1'b0, m_resp = 1'b0, m_err = 1'b0;
    bit          m_we, m_op;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;
    int          cyc = 0, m_acc = 0, m_w, m_k;
    bit          m_align;

`ifdef DM_ALIGN_CHK_EN
    assign m_align = 1'b1;
`else
    assign m_align = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 0; m_resp = 0; m_err = 0; m_rdata = 32'h0;
        end else begin
            cyc++;
            if (m_resp) begin
                if (rsp_ready) begin m_pend = 0; m_resp = 0; m_err = 0; end
            end else if (m_pend) begin
                if (cyc == m_acc + L + 1) begin
                    m_w = int'(m_addr[11:2]);
                    m_k = int'(m_addr[1:0]);
                    m_err = 0;
                    if (m_align && !m_op && m_k != 0) begin
                        m_rdata = 32'h0; m_err = 1;
                    end else if (m_we) begin
                        if (m_op) mm[m_w] = (mm[m_w] & ~(32'hFF << (8 * m_k))) | ({24'h0, m_wdata[7:0]} << (8 * m_k));
                        else      mm[m_w] = m_wdata;
                        m_rdata = 32'h0;
                    end else begin
                        m_rdata = m_op ? ((mm[m_w] >> (8 * m_k)) & 32'hFF) : mm[m_w];
                    end
                    m_resp = 1;
                end
            end else if (req_valid) begin
                m_pend = 1; m_acc = cyc;
                m_we = req_we; m_op = req_op; m_addr = req_addr; m_wdata = req_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (run && !rst) begin
            chk("req_ready", {31'h0, req_ready}, {31'h0, !m_pend});
            chk("busy", {31'h0, busy}, {31'h0, m_pend});
            chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_resp});
            if (m_resp) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
`ifdef DM_ALIGN_CHK_EN
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, m_err});
`endif
            end
        end
    end

    // Issues one request from IDLE and returns on the first negedge with rsp_valid high.
    task automatic do_req(input logic we, input logic op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input string nm);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 40) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        chk({nm, "_lat"}, n, L + 1);
        chk({nm, "_data"}, rsp_rdata, exp);
    endtask

    int pv[9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
    int pr[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

    initial begin
        int n;
        rst = 1'b1; rst1 = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_op = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0; run = 1'b1;

        do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, "t1_st");
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "t1_ld");

        do_req(1'b1, 1'b0, 32'h10, 32'h11223344, 32'h0, "t2_st");
        do_req(1'b1, 1'b1, 32'h13, 32'h555555AA, 32'h0, "t2_bst");
        do_req(1'b0, 1'b1, 32'h12, 32'h0, 32'h00000022, "t2_bld");
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hAA223344, "t2_ld");
        do_req(1'b0, 1'b0, 32'h1010, 32'h0, 32'hAA223344, "alias");

        // Response held off while a new request is pending; captured fields change under it.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_op = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h20; req_we = 1'b1; req_op = 1'b1;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        chk("t3_lat", n, L + 1);
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_valid", {31'h0, rsp_valid}, 32'h1);
            chk("t3_hold_data", rsp_rdata, 32'hAA223344);
            chk("t3_hold_rdy", {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_idle_busy", {31'h0, busy}, 32'h0);
        chk("t3_idle_rdy", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b0; req_we = 1'b0; req_op = 1'b0;

        do_req(1'b1, 1'b0, 32'h20, 32'h5, 32'h0, "t5_init");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = 1'b0; req_addr = 32'h20; req_wdata = 32'h9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t5_wait_busy", {31'h0, busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", {31'h0, busy}, 32'h0);
        chk("t5_rst_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 32'h00000005, "t5_ld");

        @(negedge clk);
        rsp_ready = 1'b0;
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hAA223344, "t5b_ld");
        #2 rst = 1'b1;
        #1;
        chk("t5b_rst_valid", {31'h0, rsp_valid}, 32'h0);
        chk("t5b_rst_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1;

`ifdef DM_ALIGN_CHK_EN
        do_req(1'b1, 1'b0, 32'h21, 32'h12345678, 32'h0, "t6_st");
        chk("t6_err_set", {31'h0, rsp_err}, 32'h1);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 32'h00000005, "t6_ld");
        chk("t6_err_clr", {31'h0, rsp_err}, 32'h0);
`endif

        // Zero wait states, requests always offered, responses always taken.
        @(negedge clk);
        rst1 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t4_rsp_valid", {31'h0, rsp_valid1}, pv[i]);
            chk("t4_req_ready", {31'h0, req_ready1}, pr[i]);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
